// File: rtl/bus_slave_sel_if.sv
// Bus-side signal bundle for bus_slave_sel: master strobe/address, per-slave
// ready and chip select, and the completion/error/busy status back to the master.
interface bus_slave_sel_if #(
  parameter int ADDR_W   = 30,
  parameter int N_SLAVES = 8
);
  logic [ADDR_W-1:0]   s_addr;
  logic                s_as_;
  logic [N_SLAVES-1:0] rdy_;
  logic [N_SLAVES-1:0] cs_;
  logic                m_rdy_;
  logic                bus_err;
  logic                busy;

  modport master (
    output s_addr, s_as_, rdy_,
    input  cs_, m_rdy_, bus_err, busy
  );

  modport slave (
    input  s_addr, s_as_, rdy_,
    output cs_, m_rdy_, bus_err, busy
  );
endinterface

// File: rtl/bus_slave_sel.sv
// Registered slave selector: latches the slave index on an address strobe, holds an
// active-low chip select for the access and ends it with ready, timeout or unmapped error.
module bus_slave_sel #(
  parameter int ADDR_W   = 30,
  parameter int IDX_W    = 3,
  parameter int N_SLAVES = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           reset_,
  bus_slave_sel_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_N = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_SLAVES-1:0] cs_q, cs_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    addr_idx_s;
  logic                mapped_s;
  logic [IDX_N-1:0]    rdy_ext_s;
  logic                sel_rdy_s;
  logic                m_rdy_s;
  logic                bus_err_s;
  logic                unused_addr_s;

  function automatic logic [N_SLAVES-1:0] cs_decode(input logic [IDX_W-1:0] idx);
    logic [N_SLAVES-1:0] cs;
    cs = '1;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        cs[i] = 1'b0;
      end else begin
        cs[i] = 1'b1;
      end
    end
    return cs;
  endfunction

  assign addr_idx_s    = bus.s_addr[ADDR_W-1 -: IDX_W];
  assign mapped_s      = ({1'b0, addr_idx_s} < (IDX_W + 1)'(N_SLAVES));
  assign unused_addr_s = ^bus.s_addr[ADDR_W-IDX_W-1:0];

  // Unimplemented index slots read as never-ready so selection stays in range.
  always_comb begin
    rdy_ext_s                 = '1;
    rdy_ext_s[N_SLAVES-1:0]   = bus.rdy_;
  end

  assign sel_rdy_s = ~rdy_ext_s[idx_q];

  // Next-state, chip-select and completion decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cs_d      = '1;
    busy_d    = 1'b0;
    m_rdy_s   = 1'b1;
    bus_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.s_as_) begin
          idx_d  = addr_idx_s;
          busy_d = 1'b1;
          if (mapped_s) begin
            state_d = ACCESS;
            cnt_d   = '0;
            cs_d    = cs_decode(addr_idx_s);
          end else begin
            state_d = ERROR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Ready takes priority over the timeout in the same cycle.
        if (sel_rdy_s) begin
          m_rdy_s = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ERROR;
          busy_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          cs_d   = cs_q;
          busy_d = 1'b1;
        end
      end
      ERROR: begin
        m_rdy_s   = 1'b0;
        bus_err_s = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index, wait counter and registered outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= '1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cs_     = cs_q;
  assign bus.busy    = busy_q;
  assign bus.m_rdy_  = m_rdy_s;
  assign bus.bus_err = bus_err_s;

endmodule
